// File: rtl/rv32m_divider.sv
// ---------------------------------------------------------------------------
// rv32m_divider
//
// Multi-cycle restoring radix-2 divider for RV32M DIV, DIVU, REM and REMU.
// It is the responder end of a valid/ready request/response handshake. A
// request is decoded and captured in IDLE. One PREP cycle takes absolute
// values, 32 ITER cycles do the shift-subtract steps, and one FIX cycle
// applies sign correction. The result is then held in DONE until the
// consumer accepts it.
//
// Optional feature (macro RV32M_DIV_EARLY_OUT_EN):
//   When defined, PREP recognises divide-by-zero, signed overflow and
//   divide-by-one. It loads the final quotient/remainder directly and skips
//   ITER, so the result appears two edges after accept. When undefined, every
//   operation takes the full 34-cycle path. Both builds produce identical
//   values.
//
// Ports:
//   iCLK      in   1     clock, rising edge
//   iRST_N    in   1     asynchronous active-low reset
//   iVALID    in   1     request valid
//   oREADY    out  1     unit idle and able to accept a request
//   iIR       in   32    instruction word (funct7/funct3/rd/opcode decoded)
//   iALU_IN1  in   XLEN  dividend (rs1)
//   iALU_IN2  in   XLEN  divisor (rs2)
//   iFLUSH    in   1     abort any in-flight operation
//   oVALID    out  1     result valid
//   iREADY    in   1     consumer accepts the result
//   oRD       out  5     destination register captured at accept
//   oALU_OUT  out  XLEN  quotient or remainder
//
// Only XLEN = 32 is supported.
// ---------------------------------------------------------------------------
module rv32m_divider #(
  parameter int XLEN = 32
) (
  input  logic            iCLK,
  input  logic            iRST_N,
  input  logic            iVALID,
  output logic            oREADY,
  input  logic [31:0]     iIR,
  input  logic [XLEN-1:0] iALU_IN1,
  input  logic [XLEN-1:0] iALU_IN2,
  input  logic            iFLUSH,
  output logic            oVALID,
  input  logic            iREADY,
  output logic [4:0]      oRD,
  output logic [XLEN-1:0] oALU_OUT
);

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    ITER,
    FIX,
    DONE
  } state_t;

  state_t          state;
  logic [XLEN-1:0] quot;     // dividend on accept, then quotient bits shift in at the LSB
  logic [XLEN-1:0] rem;      // partial remainder
  logic [XLEN-1:0] divisor;
  logic [XLEN-1:0] alu_out;
  logic [1:0]      func3;    // func3[1]: remainder op, func3[0]: unsigned op
  logic [4:0]      rd;
  logic [4:0]      count;
  logic            q_neg;
  logic            r_neg;
  logic            valid;

  logic            decode_ok;
  logic            accept;
  logic            is_signed;
  logic            sign1;
  logic            sign2;
  logic [XLEN-1:0] abs1;
  logic [XLEN-1:0] abs2;
  logic [XLEN:0]   shifted;
  logic [XLEN+1:0] trial;
  logic [XLEN-1:0] fix_result;
  logic            unused_bits;

  assign decode_ok = (iIR[6:0] == 7'b0110011) && (iIR[31:25] == 7'b0000001) && iIR[14];
  assign accept    = iVALID && decode_ok;

  // In PREP, quot and divisor still hold the raw operands.
  assign is_signed = ~func3[0];
  assign sign1     = is_signed & quot[XLEN-1];
  assign sign2     = is_signed & divisor[XLEN-1];
  assign abs1      = sign1 ? -quot : quot;
  assign abs2      = sign2 ? -divisor : divisor;

  // The widened trial keeps the borrow bit even when the shifted remainder
  // itself carries into bit XLEN.
  assign shifted = {rem, quot[XLEN-1]};
  assign trial   = {1'b0, shifted} - {2'b00, divisor};

  assign fix_result = func3[1] ? (r_neg ? -rem : rem)
                               : (q_neg ? -quot : quot);

  assign unused_bits = ^{iIR[24:15], trial[XLEN]};

`ifdef RV32M_DIV_EARLY_OUT_EN
  logic div_zero;
  logic div_one;
  logic overflow;
  logic early_out;

  assign div_zero  = (divisor == '0);
  assign div_one   = (divisor == {{(XLEN-1){1'b0}}, 1'b1});
  assign overflow  = is_signed && (quot == {1'b1, {(XLEN-1){1'b0}}}) && (divisor == '1);
  assign early_out = div_zero || div_one || overflow;
`endif

  // Main control and datapath. Flush has priority over every state, so a
  // flush alongside a request or a result acceptance always lands in IDLE.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state   <= IDLE;
      quot    <= '0;
      rem     <= '0;
      divisor <= '0;
      alu_out <= '0;
      func3   <= '0;
      rd      <= '0;
      count   <= '0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
      valid   <= 1'b0;
    end else if (iFLUSH) begin
      state <= IDLE;
      valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            quot    <= iALU_IN1;
            divisor <= iALU_IN2;
            func3   <= iIR[13:12];
            rd      <= iIR[11:7];
            state   <= PREP;
          end
        end

        PREP: begin
`ifdef RV32M_DIV_EARLY_OUT_EN
          if (early_out) begin
            // Overflow and divide-by-one both have quotient == dividend and
            // remainder 0. Divide-by-zero gives all ones and the dividend.
            // FIX then passes these through with no sign correction.
            quot  <= div_zero ? '1 : quot;
            rem   <= div_zero ? quot : '0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
            state <= FIX;
          end else
`endif
          begin
            quot    <= abs1;
            divisor <= abs2;
            rem     <= '0;
            // A zero divisor already yields an all-ones quotient, so its
            // sign must not be corrected. The remainder (|dividend|) still
            // needs the dividend's sign restored.
            q_neg   <= (sign1 ^ sign2) && (divisor != '0);
            r_neg   <= sign1;
            count   <= 5'd31;
            state   <= ITER;
          end
        end

        ITER: begin
          if (!trial[XLEN+1]) begin
            rem  <= trial[XLEN-1:0];
            quot <= {quot[XLEN-2:0], 1'b1};
          end else begin
            rem  <= shifted[XLEN-1:0];
            quot <= {quot[XLEN-2:0], 1'b0};
          end
          if (count == 5'd0) begin
            state <= FIX;
          end else begin
            count <= count - 5'd1;
          end
        end

        FIX: begin
          alu_out <= fix_result;
          valid   <= 1'b1;
          state   <= DONE;
        end

        DONE: begin
          if (iREADY) begin
            valid <= 1'b0;
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
          valid <= 1'b0;
        end
      endcase
    end
  end

  assign oREADY   = (state == IDLE);
  assign oVALID   = valid;
  assign oRD      = rd;
  assign oALU_OUT = alu_out;

endmodule

// File: tb/tb_rv32m_divider.sv
// ---------------------------------------------------------------------------
// tb_rv32m_divider
//
// Directed bench for rv32m_divider. Each request pushes its expected result,
// destination register and latency onto a scoreboard queue. The entry is
// popped and compared when the unit raises oVALID. Expected values come from
// constants and a small reference function built on SystemVerilog signed and
// unsigned division, plus the RISC-V corner-case rules.
// ---------------------------------------------------------------------------
module tb_rv32m_divider;

  localparam int FULL_LAT = 34;
`ifdef RV32M_DIV_EARLY_OUT_EN
  localparam int EARLY_LAT = 2;
`else
  localparam int EARLY_LAT = 34;
`endif

  typedef struct {
    logic [31:0] value;
    logic [4:0]  rd;
    int          lat;
  } exp_t;

  logic        iCLK;
  logic        iRST_N;
  logic        iVALID;
  logic        oREADY;
  logic [31:0] iIR;
  logic [31:0] iALU_IN1;
  logic [31:0] iALU_IN2;
  logic        iFLUSH;
  logic        oVALID;
  logic        iREADY;
  logic [4:0]  oRD;
  logic [31:0] oALU_OUT;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  rv32m_divider #(.XLEN(32)) dut (
    .iCLK     (iCLK),
    .iRST_N   (iRST_N),
    .iVALID   (iVALID),
    .oREADY   (oREADY),
    .iIR      (iIR),
    .iALU_IN1 (iALU_IN1),
    .iALU_IN2 (iALU_IN2),
    .iFLUSH   (iFLUSH),
    .oVALID   (oVALID),
    .iREADY   (iREADY),
    .oRD      (oRD),
    .oALU_OUT (oALU_OUT)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  function automatic logic [31:0] mk_ir(input logic [2:0] f3, input logic [4:0] rdi);
    return {7'b0000001, 5'd2, 5'd1, f3, rdi, 7'b0110011};
  endfunction

  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sbv;
    logic               ovf;
    sa  = a;
    sbv = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'b100:  return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(sa / sbv));
      3'b101:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110:  return (b == 0) ? a : (ovf ? 32'h0 : 32'(sa % sbv));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int lat_for(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if ((b == 0) || (b == 1) || (!f3[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)))
      return EARLY_LAT;
    return FULL_LAT;
  endfunction

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Drives one request for a single edge and records its expectation.
  task automatic applyStimulus(input string tag, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] rdi);
    exp_t e;
    check({tag, "_ready"}, {31'b0, oREADY}, 32'd1);
    e.value = ref_result(f3, a, b);
    e.rd    = rdi;
    e.lat   = lat_for(f3, a, b);
    sb_q.push_back(e);
    iIR      = mk_ir(f3, rdi);
    iALU_IN1 = a;
    iALU_IN2 = b;
    iVALID   = 1'b1;
    @(posedge iCLK);
    #1;
    iVALID = 1'b0;
  endtask

  // Waits for the result and compares it against the scoreboard. Optionally
  // holds iREADY low for 'hold' cycles while offering a new request, and
  // optionally releases with iFLUSH together with iREADY.
  task automatic checkOutput(input string tag, input int hold, input bit use_flush);
    exp_t e;
    int   cyc;
    cyc = 0;
    while (!oVALID && cyc < 200) begin
      @(posedge iCLK);
      #1;
      cyc++;
    end
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb_q.pop_front();
    check({tag, "_latency"}, 32'(cyc), 32'(e.lat));
    check({tag, "_value"}, oALU_OUT, e.value);
    check({tag, "_rd"}, {27'b0, oRD}, {27'b0, e.rd});
    check({tag, "_busy"}, {31'b0, oREADY}, 32'd0);
    if (hold > 0) iVALID = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge iCLK);
      #1;
      check({tag, "_hold_valid"}, {31'b0, oVALID}, 32'd1);
      check({tag, "_hold_value"}, oALU_OUT, e.value);
      check({tag, "_hold_rd"}, {27'b0, oRD}, {27'b0, e.rd});
      check({tag, "_hold_busy"}, {31'b0, oREADY}, 32'd0);
    end
    iREADY = 1'b1;
    iFLUSH = use_flush;
    @(posedge iCLK);
    #1;
    iREADY = 1'b0;
    iFLUSH = 1'b0;
    iVALID = 1'b0;
    check({tag, "_drop_valid"}, {31'b0, oVALID}, 32'd0);
    check({tag, "_idle_ready"}, {31'b0, oREADY}, 32'd1);
  endtask

  initial begin
    exp_t drop;
    bit   saw_valid;
    iRST_N   = 1'b0;
    iVALID   = 1'b0;
    iIR      = '0;
    iALU_IN1 = '0;
    iALU_IN2 = '0;
    iFLUSH   = 1'b0;
    iREADY   = 1'b0;
    #12;
    check("reset_ready", {31'b0, oREADY}, 32'd1);
    check("reset_valid", {31'b0, oVALID}, 32'd0);
    check("reset_out", oALU_OUT, 32'd0);
    check("reset_rd", {27'b0, oRD}, 32'd0);
    iRST_N = 1'b1;
    @(posedge iCLK);
    #1;
    check("post_reset_ready", {31'b0, oREADY}, 32'd1);

    $display("[TB] basic signed/unsigned operations");
    applyStimulus("div_neg", 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd5);
    checkOutput("div_neg", 0, 1'b0);
    applyStimulus("rem_neg", 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd6);
    checkOutput("rem_neg", 0, 1'b0);
    applyStimulus("remu", 3'b111, 32'hFFFF_FFF9, 32'd2, 5'd7);
    checkOutput("remu", 0, 1'b0);
    applyStimulus("divu", 3'b101, 32'hFFFF_FFF9, 32'd2, 5'd8);
    checkOutput("divu", 0, 1'b0);

    $display("[TB] corner cases");
    applyStimulus("divu_zero", 3'b101, 32'h1234_5678, 32'd0, 5'd9);
    checkOutput("divu_zero", 0, 1'b0);
    applyStimulus("remu_zero", 3'b111, 32'h1234_5678, 32'd0, 5'd10);
    checkOutput("remu_zero", 0, 1'b0);
    applyStimulus("div_zero_neg", 3'b100, 32'hFFFF_FFF9, 32'd0, 5'd11);
    checkOutput("div_zero_neg", 0, 1'b0);
    applyStimulus("rem_zero_neg", 3'b110, 32'hFFFF_FFF9, 32'd0, 5'd12);
    checkOutput("rem_zero_neg", 0, 1'b0);
    applyStimulus("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13);
    checkOutput("div_ovf", 0, 1'b0);
    applyStimulus("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14);
    checkOutput("rem_ovf", 0, 1'b0);
    applyStimulus("div_one", 3'b100, 32'hFFFF_FF00, 32'd1, 5'd15);
    checkOutput("div_one", 0, 1'b0);
    applyStimulus("rem_one", 3'b110, 32'hFFFF_FF00, 32'd1, 5'd16);
    checkOutput("rem_one", 0, 1'b0);

    $display("[TB] backpressure, ignored request while busy");
    applyStimulus("bp", 3'b101, 32'd1000, 32'd3, 5'd17);
    checkOutput("bp", 5, 1'b0);
    applyStimulus("after_bp", 3'b111, 32'd1000, 32'd3, 5'd18);
    checkOutput("after_bp", 0, 1'b0);

    $display("[TB] flush together with ready in DONE");
    applyStimulus("flush_done", 3'b100, 32'd20, 32'hFFFF_FFFD, 5'd19);
    checkOutput("flush_done", 0, 1'b1);

    $display("[TB] random operations against reference");
    for (int i = 0; i < 8; i++) begin
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      f3 = 3'b100 + 3'(i % 4);
      a  = $urandom;
      b  = (i % 2 == 1) ? 32'($urandom_range(2, 50)) : $urandom;
      if (i == 2) a = 32'h8000_0001;
      applyStimulus("rand", f3, a, b, 5'(20 + i));
      checkOutput("rand", 0, 1'b0);
    end

    $display("[TB] flush during ITER");
    applyStimulus("flush_iter", 3'b101, 32'd12345, 32'd17, 5'd3);
    repeat (11) begin
      @(posedge iCLK);
      #1;
    end
    iFLUSH = 1'b1;
    @(posedge iCLK);
    #1;
    iFLUSH = 1'b0;
    drop = sb_q.pop_front();
    check("flush_iter_ready", {31'b0, oREADY}, 32'd1);
    saw_valid = 1'b0;
    repeat (40) begin
      @(posedge iCLK);
      #1;
      if (oVALID) saw_valid = 1'b1;
    end
    check("flush_iter_no_valid", {31'b0, saw_valid}, 32'd0);

    $display("[TB] decode filter and flush in IDLE");
    iIR      = mk_ir(3'b000, 5'd4);
    iALU_IN1 = 32'd6;
    iALU_IN2 = 32'd7;
    iVALID   = 1'b1;
    @(posedge iCLK);
    #1;
    iVALID = 1'b0;
    check("mul_ignored_ready", {31'b0, oREADY}, 32'd1);
    iIR    = mk_ir(3'b100, 5'd4);
    iVALID = 1'b1;
    iFLUSH = 1'b1;
    @(posedge iCLK);
    #1;
    iVALID = 1'b0;
    iFLUSH = 1'b0;
    check("flush_idle_ready", {31'b0, oREADY}, 32'd1);
    saw_valid = 1'b0;
    repeat (40) begin
      @(posedge iCLK);
      #1;
      if (oVALID || !oREADY) saw_valid = 1'b1;
    end
    check("ignored_stays_idle", {31'b0, saw_valid}, 32'd0);

    $display("[TB] asynchronous reset mid-ITER");
    applyStimulus("reset_iter", 3'b100, 32'd5000, 32'd9, 5'd21);
    repeat (10) begin
      @(posedge iCLK);
      #1;
    end
    #2;
    iRST_N = 1'b0;
    #1;
    check("async_rst_ready", {31'b0, oREADY}, 32'd1);
    check("async_rst_valid", {31'b0, oVALID}, 32'd0);
    check("async_rst_out", oALU_OUT, 32'd0);
    check("async_rst_rd", {27'b0, oRD}, 32'd0);
    drop = sb_q.pop_front();
    @(posedge iCLK);
    #1;
    iRST_N = 1'b1;
    @(posedge iCLK);
    #1;
    applyStimulus("div_100_7", 3'b100, 32'd100, 32'd7, 5'd22);
    checkOutput("div_100_7", 0, 1'b0);
    check("div_100_7_const", ref_result(3'b100, 32'd100, 32'd7), 32'd14);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
